// File: rtl/bitonic_sort_folded.sv
// -----------------------------------------------------------------------------
// bitonic_sort_folded
//
// Folded bitonic sorter with argsort tags. A single column of N/2
// compare-exchange units is reused for every bitonic pass. One pass runs per
// clock, so a job of N = 2**LOG_INPUT_NUM keys takes P = L(L+1)/2 cycles.
// Each key carries its original index as a tag. The tag swaps together with
// its key, so y_idx gives the argsort permutation.
//
// Parameters:
//   LOG_INPUT_NUM  log2 of the element count N (1..6)
//   DATA_WIDTH     bits per key
//   SIGNED         1 = keys compare as two's complement, 0 = unsigned
//   IDX_WIDTH      bits per tag (derived from LOG_INPUT_NUM, do not override)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   x_valid  input job valid
//   x_ready  sorter can accept a job
//   x        packed keys, element 0 in the low DATA_WIDTH bits
//   x_desc   0 = ascending, 1 = descending; sampled with the job
//   y        sorted keys, same packing as x
//   y_idx    original index of each output key
//   y_valid  result valid, held until y_ready
//   y_ready  downstream accepts the result
//   busy     high while a job is sorting or waiting for its result handshake
//   abort    (only when BITONIC_ABORT_EN is defined) drops the current job
//
// Optional feature macro: BITONIC_ABORT_EN
// -----------------------------------------------------------------------------
module bitonic_sort_folded #(
    parameter int LOG_INPUT_NUM = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int SIGNED        = 0,
    parameter int IDX_WIDTH     = LOG_INPUT_NUM
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          x_valid,
    output logic                                          x_ready,
    input  logic [DATA_WIDTH*(1<<LOG_INPUT_NUM)-1:0]      x,
    input  logic                                          x_desc,
    output logic [DATA_WIDTH*(1<<LOG_INPUT_NUM)-1:0]      y,
    output logic [IDX_WIDTH*(1<<LOG_INPUT_NUM)-1:0]       y_idx,
    output logic                                          y_valid,
    input  logic                                          y_ready,
`ifdef BITONIC_ABORT_EN
    input  logic                                          abort,
`endif
    output logic                                          busy
);

    localparam int N    = 1 << LOG_INPUT_NUM;
    localparam int HALF = N / 2;
    // The counter must hold the stage value L, which is one more than any
    // substage index.
    localparam int SW   = $clog2(LOG_INPUT_NUM + 1);

    // Flipping the MSB maps two's complement order onto unsigned order. This
    // lets one unsigned comparator serve both modes.
    localparam logic [DATA_WIDTH-1:0] SIGN_FLIP =
        {(SIGNED != 0), {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [SW-1:0]          stage_reg;   // k: 1..L during SORT
    logic [SW-1:0]          sub_reg;     // j: k-1 down to 0
    logic                   desc_reg;

    logic [DATA_WIDTH-1:0]  key_reg  [N];
    logic [IDX_WIDTH-1:0]   tag_reg  [N];
    logic [DATA_WIDTH-1:0]  key_next [N];
    logic [IDX_WIDTH-1:0]   tag_next [N];

    logic                   last_pass;
    logic                   abort_hit;

`ifdef BITONIC_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign last_pass = (stage_reg == SW'(LOG_INPUT_NUM)) && (sub_reg == '0);

    // The lower element of pair number 'unit' at substage j is found by
    // inserting a zero at bit position j of 'unit'.
    function automatic logic [IDX_WIDTH-1:0] pair_lo(input int unit, input int j);
        int low_bits;
        low_bits = unit & ((1 << j) - 1);
        return IDX_WIDTH'(((unit >> j) << (j + 1)) | low_bits);
    endfunction

    // Base direction comes from bit k of the lower index. In the final stage,
    // k = L is above every index bit, so all pairs sort ascending.
    function automatic logic base_desc(input logic [IDX_WIDTH-1:0] i,
                                       input logic [SW-1:0] k);
        int iv;
        iv = int'(i);
        return ((iv >> k) & 1) == 1;
    endfunction

    // ---------------------------------------------------------------------
    // Compare-exchange column
    // ---------------------------------------------------------------------
    logic [IDX_WIDTH-1:0]   lo_idx      [HALF];
    logic [IDX_WIDTH-1:0]   hi_idx      [HALF];
    logic [DATA_WIDTH-1:0]  lo_key_out  [HALF];
    logic [DATA_WIDTH-1:0]  hi_key_out  [HALF];
    logic [IDX_WIDTH-1:0]   lo_tag_out  [HALF];
    logic [IDX_WIDTH-1:0]   hi_tag_out  [HALF];

    genvar gi;
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_ce
            logic [DATA_WIDTH-1:0] key_a;
            logic [DATA_WIDTH-1:0] key_b;
            logic [DATA_WIDTH-1:0] cmp_a;
            logic [DATA_WIDTH-1:0] cmp_b;
            logic                  pair_desc;
            logic                  swap;

            assign lo_idx[gi] = pair_lo(gi, int'(sub_reg));
            assign hi_idx[gi] = lo_idx[gi] | (IDX_WIDTH'(1) << sub_reg);

            assign key_a     = key_reg[lo_idx[gi]];
            assign key_b     = key_reg[hi_idx[gi]];
            assign cmp_a     = key_a ^ SIGN_FLIP;
            assign cmp_b     = key_b ^ SIGN_FLIP;
            assign pair_desc = base_desc(lo_idx[gi], stage_reg) ^ desc_reg;

            // Swap only when the order is strictly violated. Equal keys keep
            // their positions, so tags stay deterministic.
            assign swap = pair_desc ? (cmp_a < cmp_b) : (cmp_a > cmp_b);

            assign lo_key_out[gi] = swap ? key_b : key_a;
            assign hi_key_out[gi] = swap ? key_a : key_b;
            assign lo_tag_out[gi] = swap ? tag_reg[hi_idx[gi]] : tag_reg[lo_idx[gi]];
            assign hi_tag_out[gi] = swap ? tag_reg[lo_idx[gi]] : tag_reg[hi_idx[gi]];
        end
    endgenerate

    // Scatter the unit outputs back to their bank positions. The pairs cover
    // every element exactly once, so each position is written once.
    always_comb begin
        key_next = key_reg;
        tag_next = tag_reg;
        for (int u = 0; u < HALF; u++) begin
            key_next[lo_idx[u]] = lo_key_out[u];
            key_next[hi_idx[u]] = hi_key_out[u];
            tag_next[lo_idx[u]] = lo_tag_out[u];
            tag_next[hi_idx[u]] = hi_tag_out[u];
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            stage_reg <= '0;
            sub_reg   <= '0;
            desc_reg  <= 1'b0;
            x_ready   <= 1'b0;
            y_valid   <= 1'b0;
            busy      <= 1'b0;
            y         <= '0;
            y_idx     <= '0;
            for (int i = 0; i < N; i++) begin
                key_reg[i] <= '0;
                tag_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (x_valid && x_ready) begin
                        for (int i = 0; i < N; i++) begin
                            key_reg[i] <= x[i*DATA_WIDTH +: DATA_WIDTH];
                            tag_reg[i] <= IDX_WIDTH'(i);
                        end
                        desc_reg  <= x_desc;
                        stage_reg <= SW'(1);
                        sub_reg   <= '0;
                        x_ready   <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= SORT;
                    end else begin
                        // x_ready rises on the first edge after reset release.
                        x_ready <= 1'b1;
                    end
                end

                SORT: begin
                    if (abort_hit) begin
                        state_reg <= IDLE;
                        x_ready   <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        key_reg <= key_next;
                        tag_reg <= tag_next;
                        if (last_pass) begin
                            for (int i = 0; i < N; i++) begin
                                y[i*DATA_WIDTH +: DATA_WIDTH] <= key_next[i];
                                y_idx[i*IDX_WIDTH +: IDX_WIDTH] <= tag_next[i];
                            end
                            y_valid   <= 1'b1;
                            state_reg <= DONE;
                        end else if (sub_reg == '0) begin
                            // The next stage starts at substage j = k_new - 1,
                            // which equals the current k.
                            stage_reg <= stage_reg + 1'b1;
                            sub_reg   <= stage_reg;
                        end else begin
                            sub_reg <= sub_reg - 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (abort_hit || y_ready) begin
                        y_valid   <= 1'b0;
                        x_ready   <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    x_ready   <= 1'b0;
                    y_valid   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitonic_sort_folded.sv
// -----------------------------------------------------------------------------
// Testbench for bitonic_sort_folded. Two instances (unsigned and signed key
// compare) share all inputs. Table-driven sort vectors run first. Hand-written
// sequences then cover result hold, back-to-back jobs, mid-sort reset and
// (when BITONIC_ABORT_EN is defined) abort.
// -----------------------------------------------------------------------------
module tb_bitonic_sort_folded;

    localparam int L = 3;
    localparam int W = 8;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_valid;
    logic        x_desc;
    logic        y_ready;
    logic [63:0] x;
    logic [63:0] y_u, y_s;
    logic [23:0] idx_u, idx_s;
    logic        x_ready_u, x_ready_s;
    logic        y_valid_u, y_valid_s;
    logic        busy_u, busy_s;
`ifdef BITONIC_ABORT_EN
    logic        abort;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitonic_sort_folded #(.LOG_INPUT_NUM(L), .DATA_WIDTH(W), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready_u), .x(x),
        .x_desc(x_desc), .y(y_u), .y_idx(idx_u), .y_valid(y_valid_u),
        .y_ready(y_ready),
`ifdef BITONIC_ABORT_EN
        .abort(abort),
`endif
        .busy(busy_u)
    );

    bitonic_sort_folded #(.LOG_INPUT_NUM(L), .DATA_WIDTH(W), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready_s), .x(x),
        .x_desc(x_desc), .y(y_s), .y_idx(idx_s), .y_valid(y_valid_s),
        .y_ready(y_ready),
`ifdef BITONIC_ABORT_EN
        .abort(abort),
`endif
        .busy(busy_s)
    );

    typedef struct {
        logic [63:0] keys;
        logic        desc;
        logic [63:0] yu;
        logic [23:0] iu;
        logic [63:0] ys;
        logic [23:0] is_;
    } vec_t;

    vec_t vecs [5];

    // Element 0 is the first argument.
    function automatic logic [63:0] pk(input logic [7:0] e0, e1, e2, e3,
                                       input logic [7:0] e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [23:0] pi(input int e0, e1, e2, e3, e4, e5, e6, e7);
        return {3'(e7), 3'(e6), 3'(e5), 3'(e4), 3'(e3), 3'(e2), 3'(e1), 3'(e0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present a job and return after its acceptance edge.
    task automatic send(input logic [63:0] k, input logic d, input bit keep_valid);
        int n;
        n = 0;
        while (!x_ready_u && n < 30) begin
            step();
            n++;
        end
        chk("x_ready_wait", 80'(x_ready_u), 80'(1));
        x = k;
        x_desc = d;
        x_valid = 1'b1;
        step();
        if (!keep_valid) x_valid = 1'b0;
        chk("accept_busy", {78'(0), busy_u, x_ready_u}, {78'(0), 1'b1, 1'b0});
    endtask

    // Count the edges from acceptance until y_valid rises.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!y_valid_u && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic check_result(input vec_t v, input int n);
        chk($sformatf("y_u[%0d]", n),   80'(y_u),   80'(v.yu));
        chk($sformatf("idx_u[%0d]", n), 80'(idx_u), 80'(v.iu));
        chk($sformatf("y_s[%0d]", n),   80'(y_s),   80'(v.ys));
        chk($sformatf("idx_s[%0d]", n), 80'(idx_s), 80'(v.is_));
        $display("job %0d: keys=%h desc=%0d y_u=%h idx_u=%h y_s=%h idx_s=%h",
                 n, v.keys, v.desc, y_u, idx_u, y_s, idx_s);
    endtask

    task automatic handshake();
        y_ready = 1'b1;
        step();
        y_ready = 1'b0;
        chk("after_handshake", {77'(0), y_valid_u, x_ready_u, busy_u},
            {77'(0), 1'b0, 1'b1, 1'b0});
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int lat;
        send(v.keys, v.desc, 1'b0);
        wait_result(lat);
        chk($sformatf("latency[%0d]", n), 80'(lat), 80'(6));
        chk($sformatf("y_valid_s[%0d]", n), 80'(y_valid_s), 80'(1));
        check_result(v, n);
        handshake();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish by 100000");
        $fatal(1);
    end

    initial begin
        logic [63:0] ties;
        logic [63:0] y_prev;
        logic [23:0] idx_prev;
        int          lat;

        vecs[0] = '{pk(5,3,7,1,0,6,2,4), 1'b0,
                    pk(0,1,2,3,4,5,6,7), pi(4,3,6,1,7,0,5,2),
                    pk(0,1,2,3,4,5,6,7), pi(4,3,6,1,7,0,5,2)};
        vecs[1] = '{pk(5,3,7,1,0,6,2,4), 1'b1,
                    pk(7,6,5,4,3,2,1,0), pi(2,5,0,7,1,6,3,4),
                    pk(7,6,5,4,3,2,1,0), pi(2,5,0,7,1,6,3,4)};
        vecs[2] = '{pk(8'h80,8'h7F,8'h00,8'hFF,8'h01,8'hFE,8'h40,8'hC0), 1'b0,
                    pk(8'h00,8'h01,8'h40,8'h7F,8'h80,8'hC0,8'hFE,8'hFF), pi(2,4,6,1,0,7,5,3),
                    pk(8'h80,8'hC0,8'hFE,8'hFF,8'h00,8'h01,8'h40,8'h7F), pi(0,7,5,3,2,4,6,1)};
        vecs[3] = '{pk(8'h80,8'h7F,8'h00,8'hFF,8'h01,8'hFE,8'h40,8'hC0), 1'b1,
                    pk(8'hFF,8'hFE,8'hC0,8'h80,8'h7F,8'h40,8'h01,8'h00), pi(3,5,7,0,1,6,4,2),
                    pk(8'h7F,8'h40,8'h01,8'h00,8'hFF,8'hFE,8'hC0,8'h80), pi(1,6,4,2,3,5,7,0)};
        vecs[4] = '{pk(7,6,5,4,3,2,1,0), 1'b0,
                    pk(0,1,2,3,4,5,6,7), pi(7,6,5,4,3,2,1,0),
                    pk(0,1,2,3,4,5,6,7), pi(7,6,5,4,3,2,1,0)};

        rst = 1'b0;
        x_valid = 1'b0;
        x_desc = 1'b0;
        y_ready = 1'b0;
        x = '0;
`ifdef BITONIC_ABORT_EN
        abort = 1'b0;
`endif

        // Reset state
        step();
        step();
        chk("reset_ctrl", {76'(0), y_valid_u, busy_u, x_ready_u, y_valid_s},
            {76'(0), 4'b0000});
        chk("reset_y", {y_u, 16'(0)}, 80'(0));
        chk("reset_idx", 80'(idx_u), 80'(0));
        rst = 1'b1;
        #1;
        chk("x_ready_before_edge", 80'(x_ready_u), 80'(0));
        step();
        chk("x_ready_after_release", 80'(x_ready_u), 80'(1));

        // Table-driven sorts
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // All-equal keys never swap; then hold the result with y_ready low.
        ties = {8{8'h55}};
        send(ties, 1'b0, 1'b0);
        wait_result(lat);
        chk("ties_latency", 80'(lat), 80'(6));
        chk("ties_y", 80'(y_u), 80'(ties));
        chk("ties_idx", 80'(idx_u), 80'(pi(0,1,2,3,4,5,6,7)));
        chk("ties_idx_s", 80'(idx_s), 80'(pi(0,1,2,3,4,5,6,7)));
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("hold[%0d]", c), {y_valid_u, x_ready_u, busy_u, y_u, 13'(idx_u)},
                {1'b1, 1'b0, 1'b1, ties, 13'(pi(0,1,2,3,4,5,6,7))});
        end
        handshake();
        chk("ties_y_kept", 80'(y_u), 80'(ties));

        // Back-to-back: x_valid held high across the first job.
        send(vecs[0].keys, 1'b0, 1'b1);
        x = vecs[2].keys;
        x_desc = 1'b0;
        wait_result(lat);
        chk("b2b_lat_a", 80'(lat), 80'(6));
        chk("b2b_no_early_accept", 80'(x_ready_u), 80'(0));
        check_result(vecs[0], 10);
        y_ready = 1'b1;
        step();
        y_ready = 1'b0;
        chk("b2b_idle", {78'(0), x_ready_u, busy_u}, {78'(0), 1'b1, 1'b0});
        step();
        x_valid = 1'b0;
        chk("b2b_accept_b", {78'(0), x_ready_u, busy_u}, {78'(0), 1'b0, 1'b1});
        wait_result(lat);
        chk("b2b_lat_b", 80'(lat), 80'(6));
        check_result(vecs[2], 11);
        handshake();

        // Reset during pass 3 discards the job.
        send(vecs[1].keys, 1'b1, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("midrst_ctrl", {77'(0), y_valid_u, busy_u, x_ready_u}, 80'(0));
        chk("midrst_y", 80'(y_u), 80'(0));
        chk("midrst_idx", 80'(idx_u), 80'(0));
        step();
        rst = 1'b1;
        step();
        chk("midrst_release", {78'(0), x_ready_u, y_valid_u}, {78'(0), 1'b1, 1'b0});
        run_vec(vecs[3], 12);

`ifdef BITONIC_ABORT_EN
        // Abort on pass 3: back to IDLE, outputs untouched.
        y_prev = y_u;
        idx_prev = idx_u;
        send(vecs[0].keys, 1'b0, 1'b0);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_ctrl", {77'(0), y_valid_u, x_ready_u, busy_u}, {77'(0), 1'b0, 1'b1, 1'b0});
        chk("abort_y", 80'(y_u), 80'(y_prev));
        chk("abort_idx", 80'(idx_u), 80'(idx_prev));
        run_vec(vecs[1], 13);
`else
        y_prev = '0;
        idx_prev = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitonic_sort_folded.md
Name: bitonic_sort_folded

Overview:
Iterative (folded) bitonic sorter with tag tracking. It reuses one column of 2**(LOG_INPUT_NUM-1) compare-exchange units over all bitonic passes, trading latency for area against the fully unrolled network. It adds ready/valid flow control on both sides, per-job runtime sort direction and an argsort index output. It sits in the accelerator datapath in place of the unrolled sorter where comparator count matters more than throughput.

Parameters:
LOG_INPUT_NUM, 3, log2 of element count N (N=2**LOG_INPUT_NUM); legal range 1..6
DATA_WIDTH, 32, bits per key
SIGNED, 0, 1 = keys compared as two's complement; 0 = unsigned
IDX_WIDTH, LOG_INPUT_NUM, bits per tag (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
x_valid  in  1  input job valid
x_ready  out  1  sorter can accept a job
x  in  DATA_WIDTH*N  keys; x[DATA_WIDTH-1:0] is element 0
x_desc  in  1  0 = ascending, 1 = descending; sampled with the job
y  out  DATA_WIDTH*N  sorted keys, same packing as x
y_idx  out  IDX_WIDTH*N  original index of each output key
y_valid  out  1  result valid
y_ready  in  1  downstream accepts the result
busy  out  1  high in SORT or DONE

Behaviour:
- Reset (rst=0, async): FSM=IDLE; y, y_idx, pass counter = 0; y_valid=0; busy=0; x_ready=1 one cycle after release.
- FSM states IDLE, SORT, DONE. x_ready = (state==IDLE). y_valid = (state==DONE).
- IDLE: on x_valid&x_ready, latch keys into the working bank; tag i = i; latch x_desc; clear stage k=1 and substage j=0; go to SORT.
- SORT: one pass per cycle. Pair element i (bit j of i = 0) with i^(1<<j). Base direction of the pair is ascending if bit k of i is 0, else descending; for k=LOG_INPUT_NUM all pairs are ascending. XOR the base direction with the latched x_desc.
- Swap key and tag together, and only when the order is strictly violated. Equal keys never swap, so results are deterministic.
- Pass order: for k=1..L, j=k-1 down to 0. Total passes P = L(L+1)/2 (P=6 for L=3).
- On the last pass, write the bank to y/y_idx and go to DONE.
- Latency: y_valid rises P clock edges after the acceptance edge.
- DONE: y, y_idx and y_valid are held stable until y_ready=1. On the edge where y_valid&y_ready, go to IDLE; y_valid falls; y/y_idx keep their last value.
- No new job is accepted in SORT or DONE. x_valid there is ignored and the upstream must hold it. Throughput is one job per P+2 cycles minimum.
- Comparator width is DATA_WIDTH. SIGNED selects a signed or unsigned compare only; keys are never modified.
- L=1: P=1, one compare-exchange.
- rst asserted mid-SORT or in DONE: the job is discarded; state and outputs return to reset values.

Optional Feature:
Macro BITONIC_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in SORT or DONE returns the FSM to IDLE on the next edge and drops y_valid. y/y_idx are not updated with partial results. abort has priority over y_ready and over pass advance. abort in IDLE has no effect.
- Undefined: no abort port; jobs always run to completion.

Test Plan:
- L=3, W=8, asc: x={5,3,7,1,0,6,2,4} (element0 first) -> y={0,1,2,3,4,5,6,7}, y_idx={4,3,6,1,7,0,5,2}; y_valid exactly 6 edges after accept.
- Same keys, x_desc=1 -> y={7,6,5,4,3,2,1,0}, y_idx={2,5,0,7,1,6,3,4}.
- SIGNED=1: x={8'h80,8'h7F,8'h00,8'hFF,8'h01,8'hFE,8'h40,8'hC0} asc -> y={80,C0,FE,FF,00,01,40,7F}. With SIGNED=0, the same keys give y={00,01,40,7F,80,C0,FE,FF}.
- Ties: all keys 8'h55 -> y all 55, y_idx={0..7}. Then hold y_ready=0 for 10 cycles -> y/y_valid stable, x_ready=0. y_ready=1 -> IDLE next edge, x_ready=1.
- Back-to-back jobs with x_valid held high -> second job accepted on the edge after the first handshake completes, not before. Each result is correct.
- Drive rst=0 on pass 3 -> y_valid=0, y=0, busy=0 immediately. After release, a fresh job sorts correctly. With BITONIC_ABORT_EN, abort on pass 3 -> IDLE next edge, y unchanged.
